// File: rtl/sram_write_feeder.sv
// Command/data feeder for one SRAM channel of the SPI SRAM engine: buffers write
// bytes in a small FIFO and shifts them onto write_in, MSB first, on io_valid.
module sram_write_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_read,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [AW-1:0]          cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_data,
  output logic [7:0]             inst,
  output logic [AW-1:0]          address,
  output logic [AW-1:0]          byte_length,
  output logic                   write_in,
  input  logic                   io_valid,
  input  logic                   rw_done,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_reg;
  logic          read_reg;
  logic [2:0]    bit_cnt_reg;
  logic [AW-1:0] byte_cnt_reg;
  logic [7:0]    shreg_reg;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       cmd_fire;
  logic       bits_left;
  logic       shift_en;
  logic [7:0] head;

  assign full       = (count_reg == (PW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign head       = mem[rd_ptr_reg];
  assign fifo_count = count_reg;
  assign wr_ready   = !full && !rst;
  assign cmd_ready  = (state_reg == IDLE) && !rst;
  assign push       = wr_valid && wr_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  // byte_length doubles as the latched length while a command runs
  assign bits_left  = (byte_cnt_reg < byte_length);
  assign shift_en   = (state_reg == RUN) && !read_reg && io_valid && bits_left;
  assign pop        = shift_en && (bit_cnt_reg == 3'd0) && !empty;

  // At a byte boundary the head byte drives the line directly; an empty FIFO sends 0.
  always_comb begin
    write_in = 1'b0;
    if ((state_reg == RUN) && !read_reg && bits_left) begin
      if (bit_cnt_reg == 3'd0) begin
        write_in = !empty && head[7];
      end else begin
        write_in = shreg_reg[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      read_reg     <= 1'b0;
      bit_cnt_reg  <= 3'd0;
      byte_cnt_reg <= '0;
      shreg_reg    <= 8'h00;
      inst         <= 8'h00;
      address      <= '0;
      byte_length  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_len != '0) begin
              state_reg    <= RUN;
              inst         <= cmd_read ? 8'h03 : 8'h02;
              address      <= cmd_addr;
              byte_length  <= cmd_len;
              read_reg     <= cmd_read;
              underrun     <= 1'b0;
              bit_cnt_reg  <= 3'd0;
              byte_cnt_reg <= '0;
              shreg_reg    <= 8'h00;
              busy         <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rw_done) begin
            state_reg <= GAP;
            inst      <= 8'h00;
            done      <= 1'b1;
          end
          if (shift_en) begin
            if (bit_cnt_reg == 3'd0) begin
              if (empty) begin
                underrun  <= 1'b1;
                shreg_reg <= 8'h00;
              end else begin
                shreg_reg <= {head[6:0], 1'b0};
              end
            end else begin
              shreg_reg <= {shreg_reg[6:0], 1'b0};
            end
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              byte_cnt_reg <= byte_cnt_reg + AW'(1);
            end
          end
        end
        GAP: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_write_feeder.sv
// Randomised bench for sram_write_feeder: a byte queue stands in for the buffered
// data and predicts the serial stream, FIFO occupancy and status flags.
module tb_sram_write_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 24;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    wr_data;
  logic [7:0]    inst;
  logic [AW-1:0] address;
  logic [AW-1:0] byte_length;
  logic          write_in;
  logic          io_valid;
  logic          rw_done;
  logic          busy;
  logic          done;
  logic          underrun;
  logic [CW-1:0] fifo_count;

  int vectors;
  int miscompares;
  byte unsigned model_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_write_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .inst(inst), .address(address), .byte_length(byte_length),
    .write_in(write_in), .io_valid(io_valid), .rw_done(rw_done),
    .busy(busy), .done(done), .underrun(underrun), .fifo_count(fifo_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    tick();
    wr_valid = 1'b0;
    model_q.push_back(b);
  endtask

  task automatic issue_cmd(input logic rd, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = addr;
    cmd_len   = len;
    $display("txn %s addr=%06h len=%0d buffered=%0d", rd ? "read " : "write", addr, len, model_q.size());
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_rw_done();
    rw_done = 1'b1;
    tick();
    rw_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++; if (inst !== 8'h00) begin miscompares++; $display("FAIL reset_inst got=%h exp=00", inst); end
    vectors++; if (address !== '0) begin miscompares++; $display("FAIL reset_address got=%h exp=0", address); end
    vectors++; if (byte_length !== '0) begin miscompares++; $display("FAIL reset_byte_length got=%h exp=0", byte_length); end
    vectors++; if (write_in !== 1'b0) begin miscompares++; $display("FAIL reset_write_in got=%b exp=0", write_in); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_basic_write();
    logic [15:0] pattern;
    logic [7:0]  b;
    pattern = 16'hA53C;
    push_byte(8'hA5);
    push_byte(8'h3C);
    vectors++; if (fifo_count !== CW'(2)) begin miscompares++; $display("FAIL basic_count_pre got=%0d exp=2", fifo_count); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL basic_cmd_ready got=%b exp=1", cmd_ready); end
    issue_cmd(1'b0, 24'h000100, 24'd2);
    vectors++; if (inst !== 8'h02) begin miscompares++; $display("FAIL basic_inst got=%h exp=02", inst); end
    vectors++; if (address !== 24'h000100) begin miscompares++; $display("FAIL basic_address got=%h exp=000100", address); end
    vectors++; if (byte_length !== 24'd2) begin miscompares++; $display("FAIL basic_byte_length got=%0d exp=2", byte_length); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got=%b exp=1", busy); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL basic_cmd_ready_run got=%b exp=0", cmd_ready); end
    for (int i = 0; i < 16; i++) begin
      io_valid = 1'b1;
      vectors++; if (write_in !== pattern[15-i]) begin miscompares++; $display("FAIL basic_bit%0d got=%b exp=%b", i, write_in, pattern[15-i]); end
      tick();
    end
    b = model_q.pop_front();
    b = model_q.pop_front();
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL basic_count_post got=%0d exp=0", fifo_count); end
    vectors++; if (write_in !== 1'b0) begin miscompares++; $display("FAIL basic_past_len got=%b exp=0", write_in); end
    tick();
    io_valid = 1'b0;
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL basic_no_extra_pop got=%0d exp=0", fifo_count); end
    pulse_rw_done();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done got=%b exp=1", done); end
    vectors++; if (inst !== 8'h00) begin miscompares++; $display("FAIL basic_gap_inst got=%h exp=00", inst); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_gap_busy got=%b exp=1", busy); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL basic_gap_cmd_ready got=%b exp=0", cmd_ready); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got=%b exp=0", done); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle_cmd_ready got=%b exp=1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] b;
    logic [7:0] cur;
    push_byte(8'($urandom));
    issue_cmd(1'b0, 24'($urandom), 24'd3);
    for (int i = 0; i < 3; i++) begin
      cur = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
      for (int k = 0; k < 8; k++) begin
        io_valid = 1'b1;
        vectors++; if (write_in !== cur[7-k]) begin miscompares++; $display("FAIL underrun_byte%0d_bit%0d got=%b exp=%b", i, k, write_in, cur[7-k]); end
        tick();
      end
      if (i == 0) begin
        vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_early got=%b exp=0", underrun); end
      end
    end
    io_valid = 1'b0;
    vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_flag got=%b exp=1", underrun); end
    pulse_rw_done();
    tick();
    vectors++; if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
    b = 8'($urandom);
    push_byte(b);
    issue_cmd(1'b0, 24'h000010, 24'd1);
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_clear got=%b exp=0", underrun); end
    cur = model_q.pop_front();
    for (int k = 0; k < 8; k++) begin
      io_valid = 1'b1;
      vectors++; if (write_in !== cur[7-k]) begin miscompares++; $display("FAIL underrun_next_bit%0d got=%b exp=%b", k, write_in, cur[7-k]); end
      tick();
    end
    io_valid = 1'b0;
    vectors++; if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_next_flag got=%b exp=0", underrun); end
    pulse_rw_done();
    tick();
  endtask

  task automatic test_read();
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    issue_cmd(1'b1, 24'h7FFFF0, 24'd4);
    vectors++; if (inst !== 8'h03) begin miscompares++; $display("FAIL read_inst got=%h exp=03", inst); end
    vectors++; if (address !== 24'h7FFFF0) begin miscompares++; $display("FAIL read_address got=%h exp=7ffff0", address); end
    vectors++; if (byte_length !== 24'd4) begin miscompares++; $display("FAIL read_byte_length got=%0d exp=4", byte_length); end
    for (int i = 0; i < 64; i++) begin
      io_valid = (i % 2 == 0);
      vectors++; if (write_in !== 1'b0) begin miscompares++; $display("FAIL read_write_in cycle%0d got=%b exp=0", i, write_in); end
      tick();
      vectors++; if (fifo_count !== CW'(model_q.size())) begin miscompares++; $display("FAIL read_count cycle%0d got=%0d exp=%0d", i, fifo_count, model_q.size()); end
    end
    io_valid = 1'b0;
    pulse_rw_done();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL read_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_zero_len();
    pulse_rw_done();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL idle_rw_done got=%b exp=0", done); end
    io_valid = 1'b1;
    tick();
    io_valid = 1'b0;
    vectors++; if (fifo_count !== CW'(model_q.size())) begin miscompares++; $display("FAIL idle_io_valid got=%0d exp=%0d", fifo_count, model_q.size()); end
    issue_cmd(1'b0, 24'h000200, 24'd0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got=%b exp=1", done); end
    vectors++; if (inst !== 8'h00) begin miscompares++; $display("FAIL zero_inst got=%h exp=00", inst); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got=%b exp=0", busy); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL zero_cmd_ready got=%b exp=1", cmd_ready); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width got=%b exp=0", done); end
  endtask

  task automatic test_random_writes();
    int         len;
    int         npush;
    logic [AW-1:0] addr;
    logic [7:0] b;
    logic       exp_under;
    bit         exp_bits[$];
    for (int t = 0; t < 8; t++) begin
      len   = $urandom_range(1, 5);
      npush = $urandom_range(0, 6);
      if (npush > DEPTH - model_q.size()) npush = DEPTH - model_q.size();
      for (int p = 0; p < npush; p++) push_byte(8'($urandom));
      vectors++; if (fifo_count !== CW'(model_q.size())) begin miscompares++; $display("FAIL rand%0d_count_pre got=%0d exp=%0d", t, fifo_count, model_q.size()); end
      addr = AW'($urandom);
      issue_cmd(1'b0, addr, AW'(len));
      vectors++; if (address !== addr) begin miscompares++; $display("FAIL rand%0d_address got=%h exp=%h", t, address, addr); end
      vectors++; if (byte_length !== AW'(len)) begin miscompares++; $display("FAIL rand%0d_len got=%0d exp=%0d", t, byte_length, len); end
      exp_bits.delete();
      exp_under = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (model_q.size() > 0) b = model_q.pop_front();
        else begin b = 8'h00; exp_under = 1'b1; end
        for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
      end
      for (int i = 0; i < exp_bits.size(); i++) begin
        io_valid = 1'b0;
        repeat ($urandom_range(0, 1)) tick();
        io_valid = 1'b1;
        vectors++; if (write_in !== exp_bits[i]) begin miscompares++; $display("FAIL rand%0d_bit%0d got=%b exp=%b", t, i, write_in, exp_bits[i]); end
        tick();
      end
      io_valid = 1'b0;
      vectors++; if (underrun !== exp_under) begin miscompares++; $display("FAIL rand%0d_underrun got=%b exp=%b", t, underrun, exp_under); end
      vectors++; if (fifo_count !== CW'(model_q.size())) begin miscompares++; $display("FAIL rand%0d_count_post got=%0d exp=%0d", t, fifo_count, model_q.size()); end
      pulse_rw_done();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rand%0d_done got=%b exp=1", t, done); end
      tick();
    end
  endtask

  task automatic test_fifo_full_wrap();
    logic       exp_rdy;
    logic       do_push;
    logic [7:0] b;
    logic [7:0] cur;
    wr_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      exp_rdy = (model_q.size() < DEPTH);
      vectors++; if (wr_ready !== exp_rdy) begin miscompares++; $display("FAIL full_wr_ready push%0d got=%b exp=%b", i, wr_ready, exp_rdy); end
      b = 8'($urandom);
      wr_data = b;
      tick();
      if (exp_rdy) model_q.push_back(b);
    end
    wr_valid = 1'b0;
    vectors++; if (fifo_count !== CW'(DEPTH)) begin miscompares++; $display("FAIL full_count got=%0d exp=%0d", fifo_count, DEPTH); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL full_wr_ready_low got=%b exp=0", wr_ready); end
    issue_cmd(1'b0, 24'h001000, AW'(3 * DEPTH));
    cur = 8'h00;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      for (int k = 0; k < 8; k++) begin
        io_valid = 1'b1;
        do_push  = 1'b0;
        if (k == 0) begin
          cur     = model_q.pop_front();
          exp_rdy = (model_q.size() + 1 < DEPTH);
          vectors++; if (wr_ready !== exp_rdy) begin miscompares++; $display("FAIL wrap_wr_ready byte%0d got=%b exp=%b", i, wr_ready, exp_rdy); end
          do_push = (i > 0) && exp_rdy;
          b = 8'($urandom);
          wr_valid = do_push;
          wr_data  = b;
        end
        vectors++; if (write_in !== cur[7-k]) begin miscompares++; $display("FAIL wrap_byte%0d_bit%0d got=%b exp=%b", i, k, write_in, cur[7-k]); end
        tick();
        wr_valid = 1'b0;
        if (do_push) model_q.push_back(b);
        if (k == 0) begin
          vectors++; if (fifo_count !== CW'(model_q.size())) begin miscompares++; $display("FAIL wrap_count byte%0d got=%0d exp=%0d", i, fifo_count, model_q.size()); end
        end
      end
    end
    io_valid = 1'b0;
    pulse_rw_done();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0]  cur;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] pattern;
    issue_cmd(1'b0, 24'h0000AA, 24'd2);
    cur = model_q[0];
    for (int k = 0; k < 3; k++) begin
      io_valid = 1'b1;
      vectors++; if (write_in !== cur[7-k]) begin miscompares++; $display("FAIL midrst_pre_bit%0d got=%b exp=%b", k, write_in, cur[7-k]); end
      tick();
    end
    io_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++; if (inst !== 8'h00) begin miscompares++; $display("FAIL midrst_inst got=%h exp=00", inst); end
    vectors++; if (address !== '0) begin miscompares++; $display("FAIL midrst_address got=%h exp=0", address); end
    vectors++; if (byte_length !== '0) begin miscompares++; $display("FAIL midrst_byte_length got=%h exp=0", byte_length); end
    vectors++; if (write_in !== 1'b0) begin miscompares++; $display("FAIL midrst_write_in got=%b exp=0", write_in); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL midrst_fifo_count got=%0d exp=0", fifo_count); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_cmd_ready got=%b exp=0", cmd_ready); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_wr_ready got=%b exp=0", wr_ready); end
    model_q.delete();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_no_done cycle%0d got=%b exp=0", c, done); end
      tick();
    end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_cmd_ready_after got=%b exp=1", cmd_ready); end
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    pattern = {b0, b1};
    push_byte(b0);
    push_byte(b1);
    issue_cmd(1'b0, 24'h123456, 24'd2);
    vectors++; if (inst !== 8'h02) begin miscompares++; $display("FAIL fresh_inst got=%h exp=02", inst); end
    for (int i = 0; i < 16; i++) begin
      io_valid = 1'b1;
      vectors++; if (write_in !== pattern[15-i]) begin miscompares++; $display("FAIL fresh_bit%0d got=%b exp=%b", i, write_in, pattern[15-i]); end
      tick();
    end
    io_valid = 1'b0;
    model_q.delete();
    vectors++; if (fifo_count !== '0) begin miscompares++; $display("FAIL fresh_count got=%0d exp=0", fifo_count); end
    pulse_rw_done();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL fresh_done got=%b exp=1", done); end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_read    = 1'b0;
    cmd_addr    = '0;
    cmd_len     = '0;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    io_valid    = 1'b0;
    rw_done     = 1'b0;
    test_reset();
    test_basic_write();
    test_underrun();
    test_read();
    test_zero_len();
    test_random_writes();
    test_fifo_full_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
